// File: rtl/acq_seq.sv
// acq_seq -- acquisition write sequencer for a circular sample buffer.
//
// Fills a pre-trigger window, keeps writing circularly until a trigger is
// accepted, optionally skips a number of sample strobes, and then fills the
// post-trigger window before flagging the buffer as full.
//
// Ports
//   Mclk      in   sole clock, rising edge
//   nReset    in   asynchronous active-low reset
//   Arm       in   start an acquisition (accepted in IDLE or DONE only)
//   Abort     in   cancel the acquisition (takes priority over Arm)
//   SmplEn    in   ADC sample strobe
//   Trig      in   trigger event (only honoured while waiting for it)
//   Depth     in   buffer depth in samples, 0 selects 2^ADDR_W
//   PerCnt    in   pre-trigger sample count
//   Delay     in   post-trigger delay in sample strobes
//   WrEn      out  buffer write enable for the current cycle
//   Wptr      out  buffer write address
//   TrigAddr  out  Wptr captured in the trigger cycle
//   Busy      out  acquisition in progress
//   Ready     out  pre-trigger fill complete
//   Trigd     out  trigger accepted
//   Full      out  acquisition complete
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for Arm, no writes
// PREFILL   | writing the first PerCnt samples
// WAIT_TRIG | circular writes until Trig
// DELAY     | no writes, counting Delay sample strobes
// POSTFILL  | writing PostCnt samples after the trigger
// DONE      | buffer complete, Wptr held, waiting for a new Arm

module acq_seq #(
    parameter int ADDR_W = 12,
    parameter int DLY_W  = 32
) (
    input  logic              Mclk,
    input  logic              nReset,
    input  logic              Arm,
    input  logic              Abort,
    input  logic              SmplEn,
    input  logic              Trig,
    input  logic [ADDR_W-1:0] Depth,
    input  logic [ADDR_W-1:0] PerCnt,
    input  logic [DLY_W-1:0]  Delay,
    output logic              WrEn,
    output logic [ADDR_W-1:0] Wptr,
    output logic [ADDR_W-1:0] TrigAddr,
    output logic              Busy,
    output logic              Ready,
    output logic              Trigd,
    output logic              Full
);

    // One extra bit so a depth of 2^ADDR_W is representable.
    localparam int CW = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFILL,
        S_WAIT_TRIG,
        S_DELAY,
        S_POSTFILL,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    depth_q;
    logic [CW-1:0]    per_q;
    logic [CW-1:0]    post_q;
    logic [DLY_W-1:0] dly_q;

    logic [CW-1:0]    pre_cnt;
    logic [CW-1:0]    post_cnt;
    logic [DLY_W-1:0] dly_cnt;

    logic [CW-1:0]    depth_eff;
    logic [CW-1:0]    per_ext;
    logic [CW-1:0]    per_clamp;

    logic arm_acc;
    logic trig_acc;
    logic wr;
    logic wr_adv;
    logic dly_adv;
    logic busy_c;
    logic wrap;

    // Settings as they would be latched by an Arm this cycle.
    always_comb begin
        depth_eff = (Depth == '0) ? (CW'(1) << ADDR_W) : CW'(Depth);
        per_ext   = CW'(PerCnt);
        per_clamp = (per_ext >= depth_eff) ? (depth_eff - CW'(1)) : per_ext;
    end

    assign wrap = ({1'b0, Wptr} == (depth_q - CW'(1)));

    always_ff @(posedge Mclk or negedge nReset) begin
        if (!nReset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        arm_acc   = 1'b0;
        trig_acc  = 1'b0;
        wr        = 1'b0;
        dly_adv   = 1'b0;
        busy_c    = 1'b0;

        case (state)
            S_IDLE: begin
                if (Arm) begin
                    arm_acc   = 1'b1;
                    state_nxt = S_PREFILL;
                end
            end
            S_PREFILL: begin
                busy_c = 1'b1;
                // The count only equals PerCnt here when PerCnt is zero:
                // leave without writing.
                if (pre_cnt == per_q) begin
                    state_nxt = S_WAIT_TRIG;
                end else if (SmplEn) begin
                    wr = 1'b1;
                    if (pre_cnt + CW'(1) == per_q) begin
                        state_nxt = S_WAIT_TRIG;
                    end
                end
            end
            S_WAIT_TRIG: begin
                busy_c = 1'b1;
                wr     = SmplEn;
                if (Trig) begin
                    trig_acc  = 1'b1;
                    state_nxt = (dly_q != '0) ? S_DELAY : S_POSTFILL;
                end
            end
            S_DELAY: begin
                busy_c = 1'b1;
                if (SmplEn) begin
                    dly_adv = 1'b1;
                    if (dly_cnt + DLY_W'(1) == dly_q) begin
                        state_nxt = S_POSTFILL;
                    end
                end
            end
            S_POSTFILL: begin
                busy_c = 1'b1;
                wr     = SmplEn;
                if (SmplEn && (post_cnt + CW'(1) == post_q)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (Arm) begin
                    arm_acc   = 1'b1;
                    state_nxt = S_PREFILL;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (Abort) begin
            state_nxt = S_IDLE;
            arm_acc   = 1'b0;
            trig_acc  = 1'b0;
            dly_adv   = 1'b0;
        end
    end

    assign WrEn   = wr;
    assign Busy   = busy_c;
    // Wptr is held on an Abort edge even if a sample is strobed alongside it.
    assign wr_adv = wr && !Abort;

    always_ff @(posedge Mclk or negedge nReset) begin
        if (!nReset) begin
            depth_q  <= '0;
            per_q    <= '0;
            post_q   <= '0;
            dly_q    <= '0;
            pre_cnt  <= '0;
            post_cnt <= '0;
            dly_cnt  <= '0;
            Wptr     <= '0;
            TrigAddr <= '0;
            Ready    <= 1'b0;
            Trigd    <= 1'b0;
            Full     <= 1'b0;
        end else begin
            if (arm_acc) begin
                depth_q  <= depth_eff;
                per_q    <= per_clamp;
                post_q   <= depth_eff - per_clamp;
                dly_q    <= Delay;
                pre_cnt  <= '0;
                post_cnt <= '0;
                dly_cnt  <= '0;
                Wptr     <= '0;
            end else begin
                if (wr_adv) begin
                    Wptr <= wrap ? '0 : Wptr + ADDR_W'(1);
                    if (state == S_PREFILL) begin
                        pre_cnt <= pre_cnt + CW'(1);
                    end
                    if (state == S_POSTFILL) begin
                        post_cnt <= post_cnt + CW'(1);
                    end
                end
                if (dly_adv) begin
                    dly_cnt <= dly_cnt + DLY_W'(1);
                end
            end

            if (trig_acc) begin
                TrigAddr <= Wptr;
            end

            if (Abort || arm_acc) begin
                Ready <= 1'b0;
                Trigd <= 1'b0;
                Full  <= 1'b0;
            end else begin
                if (state == S_PREFILL && state_nxt == S_WAIT_TRIG) begin
                    Ready <= 1'b1;
                end
                if (trig_acc) begin
                    Trigd <= 1'b1;
                end
                if (state == S_POSTFILL && state_nxt == S_DONE) begin
                    Full <= 1'b1;
                end
            end
        end
    end

endmodule
